// File: rtl/mpu_scalar_mul_seq_pkg.sv
// Shared constants and types for the MPU matrix-by-scalar sequencer.
package MpuPkg;

    localparam int unsigned MPU_WIDTH     = 8;
    localparam int unsigned MPU_ROWS      = 5;
    localparam int unsigned MPU_COLS      = 5;
    localparam int unsigned MPU_ROW_IDX_W = 3;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_READ    = 3'd1,
        S_CAPTURE = 3'd2,
        S_WRITE   = 3'd3,
        S_DONE    = 3'd4
    } state_e;

    typedef logic [MPU_COLS*MPU_WIDTH-1:0] mpu_row_t;

endpackage

// File: rtl/mpu_scalar_mul_seq_row_scale.sv
// COLS-lane signed row-by-scalar multiply with per-lane overflow detection.
// MPU_SATURATE_EN clamps each lane to the signed WIDTH range instead of wrapping.
module MpuRowScale #(
    parameter int unsigned COLS  = 5,
    parameter int unsigned WIDTH = 8
) (
    input  logic [COLS*WIDTH-1:0] row_i,
    input  logic [WIDTH-1:0]      factor_i,
    output logic [COLS*WIDTH-1:0] result_o,
    output logic                  ovf_o
);

    localparam logic signed [2*WIDTH-1:0] MAXV = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [2*WIDTH-1:0] MINV = {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    logic [COLS-1:0] lane_ovf;

    always_comb begin
        logic signed [2*WIDTH-1:0] prod;
        prod     = '0;
        result_o = '0;
        lane_ovf = '0;
        for (int unsigned c = 0; c < COLS; c++) begin
            prod        = $signed(row_i[c*WIDTH +: WIDTH]) * $signed(factor_i);
            lane_ovf[c] = (prod > MAXV) || (prod < MINV);
`ifdef MPU_SATURATE_EN
            if (prod > MAXV) begin
                result_o[c*WIDTH +: WIDTH] = MAXV[WIDTH-1:0];
            end else if (prod < MINV) begin
                result_o[c*WIDTH +: WIDTH] = MINV[WIDTH-1:0];
            end else begin
                result_o[c*WIDTH +: WIDTH] = prod[WIDTH-1:0];
            end
`else
            result_o[c*WIDTH +: WIDTH] = prod[WIDTH-1:0];
`endif
        end
    end

    assign ovf_o = |lane_ovf;

endmodule

// File: rtl/mpu_scalar_mul_seq.sv
// Row-serial matrix-by-scalar sequencer: read row, scale on shared lanes, write back.
// Lane saturation is selected by MPU_SATURATE_EN (see MpuRowScale).
module mpu_scalar_mul_seq
    import MpuPkg::*;
#(
    parameter int unsigned ROWS  = MPU_ROWS,
    parameter int unsigned COLS  = MPU_COLS,
    parameter int unsigned WIDTH = MPU_WIDTH
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic [WIDTH-1:0]         factor,
    output logic                     busy,
    output logic                     done,
    output logic                     overflow,
    output logic                     rd_en,
    output logic [MPU_ROW_IDX_W-1:0] rd_row,
    input  logic [COLS*WIDTH-1:0]    rd_data,
    output logic                     wr_en,
    input  logic                     wr_ready,
    output logic [MPU_ROW_IDX_W-1:0] wr_row,
    output logic [COLS*WIDTH-1:0]    wr_data
);

    localparam logic [MPU_ROW_IDX_W-1:0] LAST_ROW = MPU_ROW_IDX_W'(ROWS - 1);

    state_e                   state_q, state_d;
    logic [MPU_ROW_IDX_W-1:0] row_q, row_d;
    logic [WIDTH-1:0]         factor_q, factor_d;
    logic [COLS*WIDTH-1:0]    result_q, result_d;
    logic                     ovf_q, ovf_d;

    logic [COLS*WIDTH-1:0]    scaled;
    logic                     scaled_ovf;

    MpuRowScale #(
        .COLS  (COLS),
        .WIDTH (WIDTH)
    ) u_row_scale (
        .row_i    (rd_data),
        .factor_i (factor_q),
        .result_o (scaled),
        .ovf_o    (scaled_ovf)
    );

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        factor_d = factor_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    factor_d = factor;
                    ovf_d    = 1'b0;
                    row_d    = '0;
                    state_d  = S_READ;
                end
            end
            S_READ:    state_d = S_CAPTURE;
            S_CAPTURE: begin
                result_d = scaled;
                ovf_d    = ovf_q | scaled_ovf;
                state_d  = S_WRITE;
            end
            S_WRITE: begin
                // Everything stays frozen while the write port stalls.
                if (wr_ready) begin
                    if (row_q == LAST_ROW) begin
                        state_d = S_DONE;
                    end else begin
                        row_d   = row_q + MPU_ROW_IDX_W'(1);
                        state_d = S_READ;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            row_q    <= '0;
            factor_q <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            factor_q <= factor_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign rd_en    = (state_q == S_READ);
    assign wr_en    = (state_q == S_WRITE);
    assign rd_row   = row_q;
    assign wr_row   = row_q;
    assign wr_data  = result_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_mpu_scalar_mul_seq.sv
// Self-checking bench for mpu_scalar_mul_seq against an arithmetic matrix model.
module tb_mpu_scalar_mul_seq;
    import MpuPkg::*;

    logic       clock;
    logic       reset_n;
    logic       start;
    logic [7:0] factor;
    logic       busy;
    logic       done;
    logic       overflow;
    logic       rd_en;
    logic [2:0] rd_row;
    mpu_row_t   rd_data;
    logic       wr_en;
    logic       wr_ready;
    logic [2:0] wr_row;
    mpu_row_t   wr_data;

    int passed = 0;
    int total  = 0;

    logic signed [7:0] mem [5][5];
    mpu_row_t          exp_rows [5];
    mpu_row_t          wr_log [5];
    logic              exp_ovf;
    logic              prev_rd;
    logic [2:0]        prev_row;

    mpu_scalar_mul_seq #(
        .ROWS  (5),
        .COLS  (5),
        .WIDTH (8)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .start    (start),
        .factor   (factor),
        .busy     (busy),
        .done     (done),
        .overflow (overflow),
        .rd_en    (rd_en),
        .rd_row   (rd_row),
        .rd_data  (rd_data),
        .wr_en    (wr_en),
        .wr_ready (wr_ready),
        .wr_row   (wr_row),
        .wr_data  (wr_data)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic mpu_row_t pack_row(input int r);
        mpu_row_t v;
        v = '0;
        for (int c = 0; c < 5; c++) v[c*8 +: 8] = mem[r][c];
        return v;
    endfunction

    // Advance one cycle; the memory answers a read in the cycle after rd_en.
    task automatic tick();
        @(posedge clock);
        #1;
        if (prev_rd === 1'b1 && prev_row < 3'd5) rd_data = pack_row(int'(prev_row));
        else rd_data = {8'($urandom), 32'($urandom)};
        prev_rd  = rd_en;
        prev_row = rd_row;
    endtask

    task automatic fill_const(input logic signed [7:0] v);
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++) mem[r][c] = v;
    endtask

    task automatic fill_rand(input int lo, input int hi);
        int v;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++) begin
                v = int'($urandom_range(0, hi - lo)) + lo;
                mem[r][c] = 8'(v);
            end
    endtask

    task automatic compute_model(input logic [7:0] f);
        int p;
        int q;
        exp_ovf = 1'b0;
        for (int r = 0; r < 5; r++) begin
            exp_rows[r] = '0;
            for (int c = 0; c < 5; c++) begin
                p = int'(mem[r][c]) * int'($signed(f));
                if (p > 127 || p < -128) exp_ovf = 1'b1;
`ifdef MPU_SATURATE_EN
                q = (p > 127) ? 127 : ((p < -128) ? -128 : p);
`else
                q = p;
`endif
                exp_rows[r][c*8 +: 8] = q[7:0];
            end
        end
    endtask

    // One full operation; stall_row/stall_len force wr_ready low on one row,
    // xs_cyc injects a start pulse (factor xs_f) in that cycle number.
    task automatic run_op(input logic [7:0] f, input int stall_row, input int stall_len,
                          input bit rand_bp, input int xs_cyc, input logic [7:0] xs_f);
        int         k;
        int         nwr;
        int         stalls;
        int         srun;
        int         done_k;
        bit         held;
        bit         rdy;
        bit         busy_ok;
        logic [2:0] hrow;
        mpu_row_t   hdata;
        compute_model(f);
        nwr = 0; stalls = 0; srun = 0; done_k = -1; held = 0; busy_ok = 1;
        hrow = '0; hdata = '0;
        start  = 1'b1;
        factor = f;
        tick();
        start  = 1'b0;
        factor = 8'($urandom);
        k = 1;
        while (k < 200 && done_k < 0) begin
            if (busy !== 1'b1) busy_ok = 0;
            if (rd_en === 1'b1) begin
                total++;
                if (rd_row !== 3'(nwr)) $display("FAIL rd_row: got %0d want %0d (cycle %0d)", rd_row, nwr, k);
                else passed++;
            end
            rdy = 1'b1;
            if (wr_en === 1'b1) begin
                if (held) begin
                    total++;
                    if ({wr_row, wr_data} !== {hrow, hdata})
                        $display("FAIL wr_hold: got row %0d data %h want row %0d data %h", wr_row, wr_data, hrow, hdata);
                    else passed++;
                end
                if (int'(wr_row) == stall_row && srun < stall_len) begin
                    rdy = 1'b0;
                    srun++;
                end else if (rand_bp) begin
                    rdy = ($urandom_range(0, 2) != 0);
                end
                if (rdy) begin
                    total++;
                    if (wr_row !== 3'(nwr)) $display("FAIL wr_row: got %0d want %0d", wr_row, nwr);
                    else passed++;
                    total++;
                    if (nwr >= 5 || wr_data !== exp_rows[nwr])
                        $display("FAIL wr_data row %0d: got %h want %h", nwr, wr_data, (nwr < 5) ? exp_rows[nwr] : '0);
                    else passed++;
                    if (nwr < 5) wr_log[nwr] = wr_data;
                    nwr++;
                    held = 0;
                end else begin
                    stalls++;
                    held  = 1;
                    hrow  = wr_row;
                    hdata = wr_data;
                end
            end else if (rand_bp) begin
                rdy = ($urandom_range(0, 1) != 0);
            end
            wr_ready = rdy;
            if (done === 1'b1) begin
                done_k = k;
                total++;
                if (nwr !== 5) $display("FAIL done_early: writes %0d want 5", nwr);
                else passed++;
            end
            start = (k == xs_cyc);
            if (start) factor = xs_f;
            tick();
            k++;
        end
        start    = 1'b0;
        wr_ready = 1'b1;
        total++;
        if (done_k < 0) $display("FAIL done_timeout: no done within %0d cycles", k);
        else passed++;
        total++;
        if (done_k !== 16 + stalls) $display("FAIL done_cycle: got %0d want %0d", done_k, 16 + stalls);
        else passed++;
        total++;
        if (nwr !== 5) $display("FAIL write_count: got %0d want 5", nwr);
        else passed++;
        total++;
        if (overflow !== exp_ovf) $display("FAIL overflow: got %b want %b", overflow, exp_ovf);
        else passed++;
        total++;
        if (!busy_ok) $display("FAIL busy_during_op: got 0 want 1");
        else passed++;
        total++;
        if ({busy, done} !== 2'b00) $display("FAIL idle_after_done: busy/done got %b want 00", {busy, done});
        else passed++;
    endtask

    task automatic test_reset();
        total++;
        if ({busy, done, overflow, rd_en, wr_en} !== 5'b0)
            $display("FAIL reset_flags: got %b want 00000", {busy, done, overflow, rd_en, wr_en});
        else passed++;
        total++;
        if ({rd_row, wr_row} !== 6'd0) $display("FAIL reset_rows: got %h want 0", {rd_row, wr_row});
        else passed++;
        total++;
        if (wr_data !== '0) $display("FAIL reset_wr_data: got %h want 0", wr_data);
        else passed++;
    endtask

    task automatic test_basic();
        mpu_row_t want;
        fill_const(8'sd10);
        run_op(8'd3, -1, 0, 0, -1, 8'd0);
        want = {5{8'h1E}};
        total++;
        if (wr_log[0] !== want) $display("FAIL basic_row0: got %h want %h", wr_log[0], want);
        else passed++;
        total++;
        if (wr_log[4] !== want) $display("FAIL basic_row4: got %h want %h", wr_log[4], want);
        else passed++;
    endtask

    task automatic test_overflow();
        logic [7:0] want0;
        fill_const(8'sd1);
        mem[2][0] = 8'sd100;
        run_op(8'hFE, -1, 0, 0, -1, 8'd0);
`ifdef MPU_SATURATE_EN
        want0 = 8'h80;
`else
        want0 = 8'h38;
`endif
        total++;
        if (wr_log[2][7:0] !== want0) $display("FAIL ovf_lane0: got %h want %h", wr_log[2][7:0], want0);
        else passed++;
        total++;
        if (wr_log[2][15:8] !== 8'hFE) $display("FAIL ovf_lane1: got %h want fe", wr_log[2][15:8]);
        else passed++;
        total++;
        if (overflow !== 1'b1) $display("FAIL ovf_flag: got %b want 1", overflow);
        else passed++;
    endtask

    task automatic test_backpressure();
        fill_rand(-128, 127);
        run_op(8'($urandom), 1, 4, 0, -1, 8'd0);
    endtask

    task automatic test_start_busy();
        fill_rand(-20, 20);
        run_op(8'd5, -1, 0, 0, 10, 8'd7);
    endtask

    task automatic test_reset_mid();
        bit quiet;
        fill_rand(-5, 5);
        mem[0][0] = 8'sd100;
        start    = 1'b1;
        factor   = 8'hFE;
        wr_ready = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k < 8; k++) tick();
        total++;
        if ({overflow, rd_en, wr_en, busy} !== 4'b1001)
            $display("FAIL mid_capture_state: ovf/rd/wr/busy got %b want 1001", {overflow, rd_en, wr_en, busy});
        else passed++;
        reset_n = 1'b0;
        #1;
        total++;
        if ({busy, done, overflow, rd_en, wr_en, rd_row, wr_row} !== 11'd0 || wr_data !== '0)
            $display("FAIL mid_reset_outputs: got %b/%h want 0", {busy, done, overflow, rd_en, wr_en, rd_row, wr_row}, wr_data);
        else passed++;
        quiet = 1;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (wr_en !== 1'b0 || busy !== 1'b0) quiet = 0;
        end
        reset_n = 1'b1;
        tick();
        if (wr_en !== 1'b0 || busy !== 1'b0) quiet = 0;
        total++;
        if (!quiet) $display("FAIL mid_reset_quiet: got activity want none");
        else passed++;
        fill_rand(-10, 10);
        run_op(8'(int'($urandom_range(0, 20)) - 10), -1, 0, 0, -1, 8'd0);
    endtask

    task automatic test_back_to_back();
        fill_rand(-128, 127);
        run_op(8'($urandom), -1, 0, 0, 16, 8'h55);
        fill_rand(-128, 127);
        run_op(8'($urandom), -1, 0, 0, -1, 8'd0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 4; i++) begin
            fill_rand(-128, 127);
            run_op(8'($urandom), -1, 0, 1, -1, 8'd0);
        end
    endtask

    initial begin
        reset_n  = 1'b0;
        start    = 1'b0;
        factor   = '0;
        wr_ready = 1'b0;
        rd_data  = '0;
        prev_rd  = 1'b0;
        prev_row = '0;
        repeat (2) tick();
        test_reset();
        reset_n  = 1'b1;
        wr_ready = 1'b1;
        tick();
        test_basic();
        test_overflow();
        test_backpressure();
        test_start_busy();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
